// File: rtl/prog_loader.sv
// Byte-serial program loader: header N, N {hi,lo} instruction pairs, optional checksum byte.
// Optional checksum stage enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

`ifdef PROG_LOADER_CSUM_EN
    typedef enum logic [2:0] {S_HDR, S_HI, S_LO, S_WR, S_CSUM, S_DONE, S_ERR} state_t;
    localparam state_t S_LAST = S_CSUM;
`else
    typedef enum logic [2:0] {S_HDR, S_HI, S_LO, S_WR, S_DONE} state_t;
    localparam state_t S_LAST = S_DONE;
`endif

    state_t            state, state_next;
    logic [7:0]        count, count_next;
    logic [7:0]        csum_acc, csum_next;
    logic [7:0]        hi_byte, hi_next;
    logic [ADDR_W-1:0] addr_next;
    logic [15:0]       wdata_next;
    logic              ready_next, we_next, hold_next, done_next, err_next;
    logic              xfer;

    assign xfer = in_valid && in_ready;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        count_next = count;
        csum_next  = csum_acc;
        hi_next    = hi_byte;
        addr_next  = imem_addr;
        wdata_next = imem_wdata;

        case (state)
            S_HDR: begin
                if (xfer) begin
                    count_next = in_data;
                    csum_next  = in_data;
                    state_next = (in_data == 8'd0) ? S_LAST : S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_next    = in_data;
                    csum_next  = csum_acc ^ in_data;
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    wdata_next = {hi_byte, in_data};
                    csum_next  = csum_acc ^ in_data;
                    state_next = S_WR;
                end
            end
            S_WR: begin
                addr_next  = imem_addr + ADDR_W'(1);
                count_next = count - 8'd1;
                state_next = (count == 8'd1) ? S_LAST : S_HI;
            end
`ifdef PROG_LOADER_CSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_next = (in_data == csum_acc) ? S_DONE : S_ERR;
                end
            end
            S_ERR: begin
                if (start) begin
                    state_next = S_HDR;
                    addr_next  = START_ADDR;
                    csum_next  = 8'd0;
                end
            end
`endif
            S_DONE: begin
                if (start) begin
                    state_next = S_HDR;
                    addr_next  = START_ADDR;
                    csum_next  = 8'd0;
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state they describe.
    always_comb begin
        ready_next = 1'b0;
        we_next    = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        hold_next  = 1'b1;
        case (state_next)
            S_HDR, S_HI, S_LO: ready_next = 1'b1;
            S_WR:              we_next    = 1'b1;
            S_DONE: begin
                done_next = 1'b1;
                hold_next = 1'b0;
            end
`ifdef PROG_LOADER_CSUM_EN
            S_CSUM:            ready_next = 1'b1;
            S_ERR:             err_next   = 1'b1;
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_HDR;
            count      <= 8'd0;
            csum_acc   <= 8'd0;
            hi_byte    <= 8'd0;
            imem_addr  <= START_ADDR;
            imem_wdata <= 16'd0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            csum_acc   <= csum_next;
            hi_byte    <= hi_next;
            imem_addr  <= addr_next;
            imem_wdata <= wdata_next;
            in_ready   <= ready_next;
            imem_we    <= we_next;
            core_hold  <= hold_next;
            done       <= done_next;
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end
`else
    assign err = 1'b0;

    logic unused_err_next;
    assign unused_err_next = err_next;
`endif

endmodule
